// File: rtl/usb_rst_sequencer.sv
// USB host-chip reset sequencer: timed assert pulse then settle wait, sticky DONE,
// optional level irq, and a FORCE bit for direct level control of the reset line.
module usb_rst_sequencer #(
  parameter logic [31:0] DEF_PULSE      = 32'd5000,
  parameter logic [31:0] DEF_SETTLE     = 32'd50000,
  parameter bit          RST_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);
  localparam logic LVL_A = !RST_ACTIVE_LOW;
  localparam logic LVL_D = RST_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SETTLE  = 2'd2,
    DONE_ST = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] pulse_reg;
  logic [31:0] settle_reg;
  logic        force_reg;
  logic        irq_en;
  logic        done;

  logic        wr;
  logic        ctrl_wr;
  logic        force_nxt;
  logic        start_req;
  logic        abort_req;
  logic        busy;
  logic [31:0] pulse_m1;
  logic        unused_ok;

  assign wr        = chipselect && !write_n;
  assign ctrl_wr   = wr && (address == 2'd0);
  assign force_nxt = ctrl_wr ? writedata[1] : force_reg;
  assign start_req = ctrl_wr && writedata[0] && !writedata[1];
  assign abort_req = ctrl_wr && writedata[1];
  assign busy      = (state == ASSERT) || (state == SETTLE);
  // A zero PULSE still yields a one-cycle assert.
  assign pulse_m1  = (pulse_reg == 32'd0) ? 32'd0 : pulse_reg - 32'd1;
  assign unused_ok = read_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 32'd0;
      pulse_reg  <= DEF_PULSE;
      settle_reg <= DEF_SETTLE;
      force_reg  <= 1'b1;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      irq        <= 1'b0;
      out_port   <= LVL_A;
    end else begin
      irq <= done & irq_en;
      if (ctrl_wr) begin
        force_reg <= writedata[1];
        irq_en    <= writedata[2];
      end
      if (wr && address == 2'd2) pulse_reg <= writedata;
      if (wr && address == 2'd3) settle_reg <= writedata;
      if (wr && address == 2'd1 && writedata[1]) done <= 1'b0;

      case (state)
        IDLE: begin
          if (start_req) begin
            state    <= ASSERT;
            cnt      <= pulse_m1;
            out_port <= LVL_A;
          end else begin
            out_port <= force_nxt ? LVL_A : LVL_D;
          end
        end
        ASSERT: begin
          if (abort_req) begin
            state    <= IDLE;
            out_port <= LVL_A;
          end else if (cnt == 32'd0) begin
            state    <= SETTLE;
            cnt      <= settle_reg;
            out_port <= LVL_D;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        SETTLE: begin
          if (abort_req) begin
            state    <= IDLE;
            out_port <= LVL_A;
          end else if (cnt == 32'd0) begin
            state <= DONE_ST;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DONE_ST: begin
          // Placed after the clear above so a same-cycle clear loses.
          done     <= 1'b1;
          state    <= IDLE;
          out_port <= force_nxt ? LVL_A : LVL_D;
        end
      endcase
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {29'd0, irq_en, force_reg, 1'b0};
      2'd1:    readdata = {28'd0, state, done, busy};
      2'd2:    readdata = pulse_reg;
      default: readdata = settle_reg;
    endcase
  end
endmodule
